// File: rtl/sc_point_register.sv
// Cursor position register for an 8x8 grid: row index plus one-hot column,
// with saturating row moves, rotating column shifts and an effective-move counter.
module sc_point_register #(
    parameter logic [7:0] RESET_COL = 8'b00010000
) (
    input  logic       SC_STATEMACHINEPOINT_CLOCK_50,
    input  logic       SC_STATEMACHINEPOINT_RESET_InHigh,
    input  logic       clear_InLow,
    input  logic       load0_InLow,
    input  logic       load1_InLow,
    input  logic [1:0] shiftselection_In,
    output logic [2:0] pointRow_Out,
    output logic [7:0] pointCol_Out,
    output logic       bottomsidecomparator_OutLow,
    output logic       topsidecomparator_OutLow,
    output logic       moved_Out,
    output logic [7:0] moveCount_Out
);

    logic [2:0] row_q, row_d;
    logic [7:0] col_q, col_d;
    logic [7:0] count_q, count_d;
    logic       moved_q, moved_d;
    logic       col_onehot;
    logic       move;

    assign col_onehot = (col_q != 8'd0) && ((col_q & (col_q - 8'd1)) == 8'd0);

    always_comb begin
        row_d   = row_q;
        col_d   = col_q;
        count_d = count_q;
        move    = 1'b0;
        if (!clear_InLow) begin
            row_d   = 3'd0;
            col_d   = RESET_COL;
            count_d = 8'd0;
        end else if (!load0_InLow) begin
            if (row_q != 3'd0) begin
                row_d = row_q - 3'd1;
                move  = 1'b1;
            end
        end else if (!load1_InLow) begin
            if (row_q != 3'd7) begin
                row_d = row_q + 3'd1;
                move  = 1'b1;
            end
        end else if (shiftselection_In == 2'b01) begin
            col_d = {col_q[6:0], col_q[7]};
            move  = 1'b1;
        end else if (shiftselection_In == 2'b10) begin
            col_d = {col_q[0], col_q[7:1]};
            move  = 1'b1;
        end
        // A corrupted column is repaired regardless of the command taken.
        if (!col_onehot)
            col_d = RESET_COL;
        if (move)
            count_d = count_d + 8'd1;
        moved_d = move;
    end

    always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
        if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
            row_q   <= 3'd0;
            col_q   <= RESET_COL;
            count_q <= 8'd0;
            moved_q <= 1'b0;
        end else begin
            row_q   <= row_d;
            col_q   <= col_d;
            count_q <= count_d;
            moved_q <= moved_d;
        end
    end

    assign pointRow_Out                = row_q;
    assign pointCol_Out                = col_q;
    assign moveCount_Out               = count_q;
    assign moved_Out                   = moved_q;
    assign bottomsidecomparator_OutLow = (row_q != 3'd7);
    assign topsidecomparator_OutLow    = (row_q != 3'd0);

endmodule

// File: tb/tb_sc_point_register.sv
// Directed bench for sc_point_register with hand-computed expectations.
module tb_sc_point_register;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear_n, load0_n, load1_n;
    logic [1:0] shift;
    logic [2:0] row;
    logic [7:0] col;
    logic       bottom_n, top_n, moved;
    logic [7:0] count;

    int n_total = 0;
    int n_pass  = 0;

    sc_point_register #(.RESET_COL(8'b00010000)) dut (
        .SC_STATEMACHINEPOINT_CLOCK_50     (clk),
        .SC_STATEMACHINEPOINT_RESET_InHigh (rst),
        .clear_InLow                       (clear_n),
        .load0_InLow                       (load0_n),
        .load1_InLow                       (load1_n),
        .shiftselection_In                 (shift),
        .pointRow_Out                      (row),
        .pointCol_Out                      (col),
        .bottomsidecomparator_OutLow       (bottom_n),
        .topsidecomparator_OutLow          (top_n),
        .moved_Out                         (moved),
        .moveCount_Out                     (count)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clear_n = 1'b1; load0_n = 1'b1; load1_n = 1'b1; shift = 2'b11;
    endtask

    task automatic chk_all(input string tag, input logic [2:0] er, input logic [7:0] ec,
                           input logic [7:0] en, input logic em);
        chk({tag, ".row"},   {5'd0, row}, {5'd0, er});
        chk({tag, ".col"},   col, ec);
        chk({tag, ".count"}, count, en);
        chk({tag, ".moved"}, {7'd0, moved}, {7'd0, em});
        chk({tag, ".top"},   {7'd0, top_n}, {7'd0, er != 3'd0});
        chk({tag, ".bot"},   {7'd0, bottom_n}, {7'd0, er != 3'd7});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #2;
        chk_all("rst_async", 3'd0, 8'h10, 8'd0, 1'b0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk_all("idle3", 3'd0, 8'h10, 8'd0, 1'b0);

        // Down seven rows, then saturate at the bottom
        for (int i = 1; i <= 7; i++) begin
            load1_n = 1'b0;
            tick();
            load1_n = 1'b1;
            chk_all($sformatf("down%0d", i), i[2:0], 8'h10, i[7:0], 1'b1);
        end
        tick();
        chk("down_idle.moved", {7'd0, moved}, 8'd0);
        load1_n = 1'b0;
        tick();
        load1_n = 1'b1;
        chk_all("down_sat", 3'd7, 8'h10, 8'd7, 1'b0);

        // load0 outranks load1 in the same cycle
        load0_n = 1'b0; load1_n = 1'b0;
        tick();
        idle();
        chk_all("up_prio", 3'd6, 8'h10, 8'd8, 1'b1);

        // Left shift held four cycles, wrapping bit7 -> bit0
        do_reset();
        shift = 2'b01;
        tick(); chk_all("lsh1", 3'd0, 8'h20, 8'd1, 1'b1);
        tick(); chk_all("lsh2", 3'd0, 8'h40, 8'd2, 1'b1);
        tick(); chk_all("lsh3", 3'd0, 8'h80, 8'd3, 1'b1);
        tick(); chk_all("lsh4", 3'd0, 8'h01, 8'd4, 1'b1);
        shift = 2'b00;
        tick(); chk_all("rsvd_hold", 3'd0, 8'h01, 8'd4, 1'b0);

        // Clear wins over load0 and shift at row 5
        do_reset();
        load1_n = 1'b0;
        repeat (5) tick();
        load1_n = 1'b1;
        chk_all("row5", 3'd5, 8'h10, 8'd5, 1'b1);
        clear_n = 1'b0; load0_n = 1'b0; shift = 2'b10;
        tick();
        idle();
        chk_all("clear_prio", 3'd0, 8'h10, 8'd0, 1'b0);

        load0_n = 1'b0;
        tick();
        load0_n = 1'b1;
        chk_all("up_sat", 3'd0, 8'h10, 8'd0, 1'b0);

        // 256 right shifts: count and column both wrap around
        shift = 2'b10;
        for (int i = 1; i <= 256; i++) begin
            tick();
            if (i == 1) chk("rsh1.col", col, 8'h08);
            if (i == 5) chk("rsh5.col", col, 8'h80);
        end
        idle();
        chk_all("rsh256", 3'd0, 8'h10, 8'd0, 1'b1);

        // Reset between edges during a load1 burst
        load1_n = 1'b0;
        repeat (3) tick();
        chk_all("burst3", 3'd3, 8'h10, 8'd3, 1'b1);
        #5;
        rst = 1'b1;
        #1;
        chk_all("mid_rst", 3'd0, 8'h10, 8'd0, 1'b0);
        tick();
        chk_all("rst_hold", 3'd0, 8'h10, 8'd0, 1'b0);
        #4;
        rst = 1'b0;
        tick();
        chk_all("first_after_rst", 3'd1, 8'h10, 8'd1, 1'b1);
        idle();
        tick();
        chk_all("final_idle", 3'd1, 8'h10, 8'd1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sc_point_register.md
SC_POINT_REGISTER -- requirements
Module: sc_point_register

Interface
REQ-001 The block SHALL have the parameter RESET_COL, default 8'b00010000, which is the one-hot column loaded on reset or clear.
REQ-002 SC_STATEMACHINEPOINT_CLOCK_50  input  1  system clock; all state updates on its rising edge.
REQ-003 SC_STATEMACHINEPOINT_RESET_InHigh  input  1  reset; asynchronous, active-high.
REQ-004 clear_InLow  input  1  active-low command that re-initialises the point.
REQ-005 load0_InLow  input  1  active-low command that moves the point up one row.
REQ-006 load1_InLow  input  1  active-low command that moves the point down one row.
REQ-007 shiftselection_In  input  2  column command: 01 shifts left, 10 shifts right, 11 holds, 00 is reserved and holds.
REQ-008 pointRow_Out  output  3  registered row index; 0 is the top row, 7 is the bottom row.
REQ-009 pointCol_Out  output  8  registered one-hot column; bit7 is leftmost.
REQ-010 bottomsidecomparator_OutLow  output  1  driven low while pointRow_Out==7; intended to feed back to the controller.
REQ-011 topsidecomparator_OutLow  output  1  driven low while pointRow_Out==0.
REQ-012 moved_Out  output  1  registered pulse that is high for one cycle after the position actually changes.
REQ-013 moveCount_Out  output  8  registered count of effective moves.

Function
REQ-014 Commands SHALL be sampled on each rising clock edge, and the result SHALL be visible on the outputs in the following cycle (1-cycle latency).
REQ-015 At most one command SHALL execute per cycle, in fixed priority order: clear, then load0, then load1, then column shift; lower-priority commands asserted in the same cycle SHALL be ignored.
REQ-016 Clear SHALL set the row to 0, the column to RESET_COL, and moveCount to 0, and SHALL leave moved_Out at 0.
REQ-017 Up (load0) SHALL decrement the row; when the row is 0 it SHALL hold (saturate), with no moved pulse and no count change.
REQ-018 Down (load1) SHALL increment the row; when the row is 7 it SHALL hold (saturate), with no moved pulse and no count change.
REQ-019 Shift left (01) SHALL rotate the column toward the MSB, wrapping from bit7 to bit0.
REQ-020 Shift right (10) SHALL rotate the column toward the LSB, wrapping from bit0 to bit7.
REQ-021 Column shifts SHALL always count as effective moves, including on wrap-around.
REQ-022 Each effective move SHALL increment moveCount by 1 modulo 256 (255 -> 0 wrap) and SHALL set moved_Out to 1 for exactly the next cycle.
REQ-023 Commands held over several cycles SHALL execute once per cycle; edge detection is the controller's responsibility.
REQ-024 Both comparator outputs SHALL be combinational decodes of the row register only, with no input-to-output combinational path.
REQ-025 pointCol_Out SHALL remain one-hot at all times; if a non-one-hot value is detected, it SHALL be restored to RESET_COL on the next edge.
REQ-026 When no command is active, all registers SHALL hold and moved_Out SHALL be 0.

Reset
REQ-027 Asserting the reset SHALL immediately force the following values, regardless of the clock: row=0, col=RESET_COL, moveCount=0, moved_Out=0, bottomsidecomparator_OutLow=1, topsidecomparator_OutLow=0.
REQ-028 Reset asserted mid-operation SHALL discard any command being sampled in that cycle.
REQ-029 The first command SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-030 Reset, then idle for 3 cycles -> row=0, col=8'b00010000, count=0, top=0, bottom=1, moved=0.
REQ-031 Pulse load1 low 7 times, then once more -> row steps 1..7; bottom goes 0 after the 7th pulse; the 8th pulse leaves row=7, count=7, and no moved pulse.
REQ-032 Apply shift=01 for 4 cycles from reset -> col = 00100000, 01000000, 10000000, 00000001, with count=4 and moved high each cycle.
REQ-033 Assert clear, load0 and shift=10 low/active in the same cycle at row=5 -> row=0, col=RESET_COL, count=0, moved=0.
REQ-034 Apply 256 right shifts -> count wraps to 0 and col returns to RESET_COL.
REQ-035 Assert reset between clock edges during a load1 burst -> outputs reach their reset values before the next edge, and no increment follows.
